// File: rtl/histeq_pkg.sv
// Shared constants and FSM state type for the histogram-equalization image SRAM path.
package histeq_pkg;
    localparam int PIXEL_W      = 8;
    localparam int WORD_W       = 128;
    localparam int ADDR_W       = 16;
    localparam int PIX_PER_WORD = WORD_W / PIXEL_W;
    localparam int FRAME_WORDS  = 4096;
    localparam int LANE_W       = $clog2(PIX_PER_WORD);

    typedef enum logic [1:0] {IDLE, FILL, WAIT_ACK} wr_state_t;
endpackage

// File: rtl/sram_frame_writer_if.sv
// Pixel stream, SRAM write port and frame handshake of the frame writer.
// master = writer side, slave = pixel source / SRAM / consumer side.
interface sram_frame_writer_if;
    import histeq_pkg::*;

    logic               start;
    logic               pix_valid;
    logic [PIXEL_W-1:0] pix_data;
    logic               pix_ready;
    logic               WriteEnable;
    logic [ADDR_W-1:0]  WriteAddress;
    logic [WORD_W-1:0]  WriteBus;
    logic               frame_done;
    logic               frame_ack;
    logic               busy;
    logic               frame_bank;

    modport master (
        input  start, pix_valid, pix_data, frame_ack,
        output pix_ready, WriteEnable, WriteAddress, WriteBus, frame_done, busy, frame_bank
    );

    modport slave (
        output start, pix_valid, pix_data, frame_ack,
        input  pix_ready, WriteEnable, WriteAddress, WriteBus, frame_done, busy, frame_bank
    );
endinterface

// File: rtl/pixel_packer.sv
// Lane counter plus accumulator: packs PIX_PER_WORD pixels LSB-first and registers
// the finished word separately, so the next word can start filling immediately.
module pixel_packer
    import histeq_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [PIXEL_W-1:0] in_data,
    output logic               last_lane,
    output logic               word_valid,
    output logic [WORD_W-1:0]  word
);
    logic [LANE_W-1:0]         lane;
    logic [WORD_W-PIXEL_W-1:0] acc;

    assign last_lane = (lane == LANE_W'(PIX_PER_WORD - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lane       <= '0;
            acc        <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (in_valid) begin
                if (last_lane) begin
                    word       <= {in_data, acc};
                    word_valid <= 1'b1;
                    lane       <= '0;
                end else begin
                    lane <= lane + LANE_W'(1);
                end
            end
            // the top lane goes straight into the output word, never into acc
            for (int k = 0; k < PIX_PER_WORD - 1; k++)
                if (in_valid && lane == LANE_W'(k))
                    acc[k*PIXEL_W +: PIXEL_W] <= in_data;
        end
    end
endmodule

// File: rtl/sram_frame_writer.sv
// Raster pixel loader for the 128-bit image SRAM: packs pixels, writes words, handshakes frames.
// Optional FRAME_PINGPONG_EN: two frame banks with a full-frame count so filling overlaps reading.
module sram_frame_writer
    import histeq_pkg::*;
#(
    parameter int FRAME_WORDS = histeq_pkg::FRAME_WORDS
)
(
    input  logic                clock,
    input  logic                reset,
    sram_frame_writer_if.master bus
);
    wr_state_t         state, state_nx;
    logic              xfer, last_lane, frame_last, done_evt, ack_evt;
    logic [ADDR_W-1:0] word_cnt, base, wr_addr;
    logic              done_q, bank;

    assign xfer       = bus.pix_valid && (state == FILL);
    assign frame_last = (word_cnt == ADDR_W'(FRAME_WORDS - 1));
    assign done_evt   = xfer && last_lane && frame_last;

    pixel_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (xfer),
        .in_data    (bus.pix_data),
        .last_lane  (last_lane),
        .word_valid (bus.WriteEnable),
        .word       (bus.WriteBus)
    );

`ifdef FRAME_PINGPONG_EN
    logic [1:0] full_cnt, full_nx;

    assign ack_evt = bus.frame_ack && (full_cnt != 2'd0);
    assign base    = bank ? ADDR_W'(FRAME_WORDS) : '0;

    always_comb begin
        full_nx = full_cnt;
        if (done_evt && !ack_evt)
            full_nx = full_cnt + 2'd1;
        else if (!done_evt && ack_evt)
            full_nx = full_cnt - 2'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full_cnt <= 2'd0;
            bank     <= 1'b0;
        end else begin
            full_cnt <= full_nx;
            if (done_evt)
                bank <= ~bank;
        end
    end
`else
    assign ack_evt = bus.frame_ack && (state == WAIT_ACK);
    assign base    = '0;
    assign bank    = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (bus.start) state_nx = FILL;
`ifdef FRAME_PINGPONG_EN
            FILL:     if (done_evt) state_nx = (full_nx < 2'd2) ? FILL : WAIT_ACK;
`else
            FILL:     if (done_evt) state_nx = WAIT_ACK;
`endif
            WAIT_ACK: if (ack_evt) state_nx = bus.start ? FILL : IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // address and frame_done are captured with the last pixel so they line up with WriteEnable
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            word_cnt <= '0;
            wr_addr  <= '0;
            done_q   <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= done_evt;
            if (xfer && last_lane) begin
                wr_addr  <= base + word_cnt;
                word_cnt <= frame_last ? '0 : word_cnt + ADDR_W'(1);
            end
        end
    end

    assign bus.WriteAddress = wr_addr;
    assign bus.frame_done   = done_q;
    assign bus.pix_ready    = (state == FILL);
    assign bus.busy         = (state != IDLE);
    assign bus.frame_bank   = bank;
endmodule

// File: tb/tb_sram_frame_writer.sv
// Scoreboard bench: a 4-word-frame writer for directed frame/handshake/reset tests and a
// default-size writer streaming one full 65536-pixel frame alongside.
module tb_sram_frame_writer;
    import histeq_pkg::*;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
        logic              done;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_big = 1'b1;
    int   checks = 0;
    int   errors = 0;
    wr_t  exp_q[$];

    int   big_wr = 0;
    int   big_dones = 0;
    int   big_last = -1;
    bit   big_done = 1'b0;

    sram_frame_writer_if bus();
    sram_frame_writer_if bus_big();

    sram_frame_writer #(.FRAME_WORDS(4)) dut (.clock(clk), .reset(rst), .bus(bus));
    sram_frame_writer dut_big (.clock(clk), .reset(rst_big), .bus(bus_big));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] mk_word(input logic [7:0] s);
        logic [WORD_W-1:0] w;
        for (int k = 0; k < PIX_PER_WORD; k++) w[8*k +: 8] = s + 8'(k);
        return w;
    endfunction

    task automatic exp_word(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d, input logic dn);
        wr_t e;
        e.addr = a; e.data = d; e.done = dn;
        exp_q.push_back(e);
    endtask

    // expects nw words starting at address a, pixels counting up from s; done on word 3
    task automatic exp_frame(input logic [ADDR_W-1:0] a, input logic [7:0] s, input int nw);
        for (int w = 0; w < nw; w++)
            exp_word(a + ADDR_W'(w), mk_word(s + 8'(16 * w)), w == 3);
    endtask

    // called at a negedge; returns at the negedge following the transfer
    task automatic push_pix(input logic [7:0] p);
        int t = 0;
        bus.pix_valid = 1'b1;
        bus.pix_data  = p;
        while (!bus.pix_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checks++; errors++;
            $display("FAIL pix_timeout: pix_ready low for %0d cycles, required high", t);
        end
        @(negedge clk);
        bus.pix_valid = 1'b0;
    endtask

    task automatic send_px(input logic [7:0] s, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            push_pix(s + 8'(i));
            if (gaps && $urandom_range(0, 1) == 1) @(negedge clk);
        end
    endtask

    task automatic pulse_ack_start();
        bus.frame_ack = 1'b1;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.frame_ack = 1'b0;
        bus.start     = 1'b0;
    endtask

    // scoreboard monitor for the small writer
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.WriteEnable) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: addr %0h, required no write", bus.WriteAddress);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", bus.WriteAddress, e.addr);
                    chk("wr_data", bus.WriteBus, e.data);
                    chk("frame_done", bus.frame_done, e.done);
                end
            end else if (bus.frame_done) begin
                checks++; errors++;
                $display("FAIL done_without_write: frame_done 1, required 0");
            end
        end
    end

    // monitor for the full-size writer
    always @(negedge clk) begin
        if (!rst_big && bus_big.WriteEnable) begin
            chk("big_addr", bus_big.WriteAddress, WORD_W'(big_wr));
            chk("big_word", bus_big.WriteBus, mk_word(8'(big_wr * 16)));
            if (bus_big.frame_done) begin
                big_dones++;
                big_last = int'(bus_big.WriteAddress);
            end
            big_wr++;
        end
    end

    // full-rate 65536-pixel stream into the default-size writer
    initial begin
        int i, t;
        bus_big.start = 1'b0; bus_big.pix_valid = 1'b0; bus_big.pix_data = '0; bus_big.frame_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst_big = 1'b0;
        bus_big.start = 1'b1;
        @(negedge clk);
        bus_big.start = 1'b0;
        i = 0; t = 0;
        while (i < 65536 && t < 70000) begin
            bus_big.pix_valid = 1'b1;
            bus_big.pix_data  = 8'(i);
            if (bus_big.pix_ready) i++;
            t++;
            @(negedge clk);
        end
        bus_big.pix_valid = 1'b0;
        repeat (4) @(negedge clk);
        big_done = 1'b1;
    end

    initial begin
        bus.start = 1'b0; bus.pix_valid = 1'b0; bus.pix_data = '0; bus.frame_ack = 1'b0;
        #1;
        chk("rst_we", bus.WriteEnable, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ready", bus.pix_ready, 0);
        chk("rst_done", bus.frame_done, 0);
        chk("rst_bank", bus.frame_bank, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

`ifdef FRAME_PINGPONG_EN
        // two frames fill both banks without an ack, then one ack lets frame 3 into bank 0
        bus.start = 1'b1;
        exp_frame(16'd0, 8'h00, 4);
        exp_frame(16'd4, 8'h40, 4);
        @(negedge clk);
        send_px(8'h00, 128, 1'b0);
        chk("pp_ready_full", bus.pix_ready, 0);
        chk("pp_bank_after2", bus.frame_bank, 0);
        exp_frame(16'd0, 8'h80, 4);
        pulse_ack_start();
        chk("pp_ready_after_ack", bus.pix_ready, 1);
        send_px(8'h80, 64, 1'b0);
        chk("pp_ready_full2", bus.pix_ready, 0);
        chk("pp_bank_after3", bus.frame_bank, 1);
`else
        // one ungapped frame: words 0x0F0E..0100 onward, done on addr 3, then WAIT_ACK
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        exp_word(16'd0, 128'h0F0E0D0C0B0A09080706050403020100, 1'b0);
        exp_word(16'd1, 128'h1F1E1D1C1B1A19181716151413121110, 1'b0);
        exp_word(16'd2, 128'h2F2E2D2C2B2A29282726252423222120, 1'b0);
        exp_word(16'd3, 128'h3F3E3D3C3B3A39383736353433323130, 1'b1);
        send_px(8'h00, 64, 1'b0);
        chk("t1_ready_wait", bus.pix_ready, 0);
        chk("t1_busy_wait", bus.busy, 1);

        // start without ack is ignored in WAIT_ACK
        bus.start = 1'b1;
        repeat (3) @(negedge clk);
        chk("t4_ready_noack", bus.pix_ready, 0);
        chk("t4_busy_noack", bus.busy, 1);
        bus.start = 1'b0;
        pulse_ack_start();
        chk("t4_ready_ack", bus.pix_ready, 1);

        // two gapped frames give the same words as ungapped ones
        exp_frame(16'd0, 8'h40, 4);
        send_px(8'h40, 64, 1'b1);
        chk("t2_ready_wait_a", bus.pix_ready, 0);
        pulse_ack_start();
        exp_frame(16'd0, 8'h80, 4);
        send_px(8'h80, 64, 1'b1);
        chk("t2_ready_wait_b", bus.pix_ready, 0);

        // ack without start returns to idle
        bus.frame_ack = 1'b1;
        @(negedge clk);
        bus.frame_ack = 1'b0;
        chk("idle_busy", bus.busy, 0);

        // async reset 10 pixels into word 2: no write at addr 2, restart writes addr 0
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        exp_frame(16'd0, 8'hC0, 2);
        send_px(8'hC0, 42, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("ar_we", bus.WriteEnable, 0);
        chk("ar_addr", bus.WriteAddress, 0);
        chk("ar_bus", bus.WriteBus, 0);
        chk("ar_busy", bus.busy, 0);
        chk("ar_ready", bus.pix_ready, 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        exp_frame(16'd0, 8'h10, 4);
        send_px(8'h10, 64, 1'b0);
        chk("ar_ready_wait", bus.pix_ready, 0);
`endif

        repeat (3) @(negedge clk);
        chk("exp_q_drained", WORD_W'(exp_q.size()), 0);

        for (int t = 0; t < 80000 && !big_done; t++) @(negedge clk);
        chk("big_finished", big_done, 1);
        chk("big_writes", WORD_W'(big_wr), 4096);
        chk("big_dones", WORD_W'(big_dones), 1);
        chk("big_last_addr", WORD_W'(big_last), 16'h0FFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
